uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer directly downstream of the UART receiver. Captures each byte the receiver delivers on its one-cycle `rx_received` strobe, whether or not the CPU is ready, and holds it in a first-word-fall-through FIFO. The CPU drains the FIFO with a read strobe. This decouples the serial line from CPU bus latency and flags bytes lost to overflow.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `IRQ_LEVEL`, 1: fill level at or above which `irq` asserts (only with the IRQ macro); legal range 1..2^DEPTH_LOG2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_data`  in  8  byte from the receiver; valid only in cycles where `rx_received`=1 (high-Z otherwise).
- `rx_received`  in  1  receiver's byte-complete strobe.
- `rd`  in  1  pop strobe from the CPU side; one byte per cycle high.
- `clr`  in  1  synchronous flush; empties the FIFO and clears `overrun`.
- `dout`  out  8  head-of-FIFO byte; 8'h00 when `empty`=1.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `count`  out  DEPTH_LOG2+1  current fill level, 0..2^DEPTH_LOG2.
- `overrun`  out  1  sticky flag: at least one byte was dropped.
- `irq`  out  1  level interrupt (see Configuration).

## Operation
- Write detect: rising edge of `rx_received`, using a registered copy `rx_received_d`. The write condition is `rx_received & ~rx_received_d`. `rx_data` is sampled in that same cycle, never later, because the bus is high-Z afterwards. A strobe held high for several cycles yields exactly one write.
- Storage: 2^DEPTH_LOG2 x 8 memory, write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits. Pointers wrap modulo the depth. `count` is tracked as a separate register rather than derived from the pointers.
- Pop: takes effect when `rd`=1 and `empty`=0. It advances `rp` and decrements `count`. `rd` while empty is ignored; there is no underflow flag and no state change.
- Write when not full: store at `wp`, advance `wp`, increment `count`.
- Write when full with no valid pop in the same cycle: the byte is dropped, `overrun` is set to 1, and pointers and count are unchanged.
- Simultaneous write and pop:
  - When full: both succeed; `count` stays at max and no overrun occurs.
  - When empty: the pop is ignored and the write succeeds, so `count` becomes 1.
  - Otherwise: both succeed and `count` is unchanged.
- Priority: `rst` > `clr` > write/pop. `clr` zeroes `wp`, `rp`, `count` and `overrun`. A write arriving in the same cycle as `clr` is discarded. `clr` does not clear `rx_received_d`, so a strobe that is still high after `clr` is not re-captured.
- `overrun` remains set until `clr` or `rst`. Pops do not clear it.
- Memory contents are not reset; `dout` masking covers the empty case.

## Timing
- Reset values: `dout`=8'h00, `empty`=1, `full`=0, `count`=0, `overrun`=0, `irq`=0. Internal: `wp`=`rp`=0, `rx_received_d`=0.
- Write latency: a strobe sampled at edge N updates `count`, `empty` and `full` after edge N. `dout` shows the byte in cycle N+1 when the FIFO was empty.
- Pop: `dout` is combinational from `mem[rp]`, with first-word fall-through. After the pop edge, `dout` shows the next byte, or 8'h00 if the FIFO is now empty.
- Flags are registered or derived from registered `count`; there is no combinational path from `rd` to the flags.
- Throughput: one write and one pop per cycle. The receiver delivers at most one byte every ~10 bit times.
- Reset mid-stream: all state clears in one cycle, and any byte strobed in the reset cycle is lost.

## Configuration
- Macro `UART_RX_FIFO_IRQ_EN`.
- Defined: `irq` is a registered output, high when `count` >= `IRQ_LEVEL` or `overrun`=1. It updates one cycle after the `count` or `overrun` change and deasserts one cycle after the FIFO drains below `IRQ_LEVEL` with `overrun` clear.
- Undefined: `irq` is tied to 0, `IRQ_LEVEL` is unused, and no comparator is synthesised.

## Test plan
- Reset, then write 8'hA5 via a one-cycle strobe -> `empty`=0, `count`=1, `dout`=8'hA5 next cycle. `rd` pulse -> `empty`=1, `dout`=8'h00.
- Write 8'h01..8'h10 (16 bytes) -> `full`=1, `count`=16. 17th write 8'h11 -> `overrun`=1 and the byte is dropped. Popping 16 times returns 8'h01..8'h10 in order.
- Full FIFO with write 8'h55 and `rd` in the same cycle -> `count` stays 16, `overrun` stays 0, and 8'h55 is the last byte popped.
- `rx_received` held high 3 cycles with 8'h3C -> exactly one entry, `count`=1. `rd` on an empty FIFO -> no change, `count` stays 0.
- 5 bytes queued with `overrun`=1, then `clr` asserted with a simultaneous write -> next cycle `count`=0, `empty`=1, `overrun`=0, and the write is discarded.
- With `UART_RX_FIFO_IRQ_EN` and `IRQ_LEVEL`=4: 3 writes -> `irq`=0. 4th write -> `irq`=1 one cycle later. One pop -> `irq`=0 one cycle later.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Byte/status bundle between the UART receive path, the receive FIFO and the CPU side.
// master: receiver + CPU strobes; slave: the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          rx_data;
  logic                rx_received;
  logic                rd;
  logic                clr;
  logic [7:0]          dout;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;
  logic                irq;

  modport master (
    output rx_data, rx_received, rd, clr,
    input  dout, empty, full, count, overrun, irq
  );

  modport slave (
    input  rx_data, rx_received, rd, clr,
    output dout, empty, full, count, overrun, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT byte FIFO: one write per rx_received rising edge, dout visible the cycle after.
// No backpressure to the receiver: writes when full are dropped and latch overrun. Optional irq: UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
    $error("uart_rx_fifo: IRQ_LEVEL must be within 1..2^DEPTH_LOG2");
  end

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  ovr;
  logic                  rx_received_d;

  logic wr_stb;
  logic pop;
  logic wr_ok;
  logic is_empty;
  logic is_full;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign wr_stb   = bus.rx_received & ~rx_received_d;
  assign pop      = bus.rd & ~is_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the incoming byte.
  assign wr_ok    = wr_stb & (~is_full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      ovr           <= 1'b0;
      rx_received_d <= 1'b0;
    end else begin
      rx_received_d <= bus.rx_received;
      if (bus.clr) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        ovr <= 1'b0;
      end else begin
        if (wr_ok) wp <= wp + 1'b1;
        if (pop)   rp <= rp + 1'b1;
        if (wr_stb && !wr_ok) ovr <= 1'b1;
        unique case ({wr_ok, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Storage is left unreset; dout masking hides stale contents.
  always_ff @(posedge clk) begin
    if (!rst && !bus.clr && wr_ok) mem[wp] <= bus.rx_data;
  end

  assign bus.dout    = is_empty ? 8'h00 : mem[rp];
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.count   = cnt;
  assign bus.overrun = ovr;

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [DEPTH_LOG2:0] IRQ_CNT = (DEPTH_LOG2 + 1)'(IRQ_LEVEL);
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (cnt >= IRQ_CNT) | ovr;
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif
endmodule
